// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect
// and the decode handshake. The fetch unit uses the master modport.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [63:0] id_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output id_valid,
        output id_instruction,
        output id_pc,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  id_valid,
        input  id_instruction,
        input  id_pc,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        output id_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// RISC-V fetch stage: PC register, 2-deep outstanding-request PC queue,
// 2-entry {instruction, pc} output buffer and a drop counter for redirects.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    logic [63:0] fetchPc_q, fetchPc_d;
    logic [63:0] pendPc_q [2];
    logic [63:0] pendPc_d [2];
    logic [1:0]  pendCnt_q, pendCnt_d;
    logic [31:0] bufInstr_q [2];
    logic [31:0] bufInstr_d [2];
    logic [63:0] bufPc_q [2];
    logic [63:0] bufPc_d [2];
    logic        rdPtr_q, rdPtr_d;
    logic        wrPtr_q, wrPtr_d;
    logic [1:0]  bufCnt_q, bufCnt_d;
    logic [1:0]  dropCnt_q, dropCnt_d;

    logic        idValid;
    logic        reqValid;
    logic        reqFire;
    logic        popHead;
    logic        respKeep;
    logic [1:0]  bufCntAfterTake;
    logic [2:0]  creditsUsed;

    // A head taken by decode this cycle frees its slot immediately, which is
    // what sustains one instruction per cycle with a single-cycle memory.
    assign idValid         = (bufCnt_q != 2'd0);
    assign bufCntAfterTake = bufCnt_q - {1'b0, idValid && bus.id_ready};
    assign creditsUsed     = {1'b0, bufCntAfterTake} + {1'b0, pendCnt_q} + {1'b0, dropCnt_q};
    assign reqValid        = !rst && !bus.redirect_valid && (creditsUsed < 3'd2);
    assign reqFire         = reqValid && bus.imem_req_ready;
    assign popHead         = idValid && bus.id_ready && !bus.redirect_valid;
    assign respKeep        = bus.imem_resp_valid && (dropCnt_q == 2'd0) && !bus.redirect_valid;

    always_comb begin
        fetchPc_d = fetchPc_q;
        if (bus.redirect_valid) begin
            fetchPc_d = {bus.redirect_pc[63:2], 2'b00};
        end else if (reqFire) begin
            fetchPc_d = fetchPc_q + 64'd4;
        end
    end

    // Every response pops the outstanding queue, kept or dropped.
    always_comb begin
        pendPc_d  = pendPc_q;
        pendCnt_d = pendCnt_q;
        if (bus.imem_resp_valid) begin
            pendPc_d[0] = pendPc_q[1];
            pendCnt_d   = pendCnt_q - 2'd1;
        end
        if (reqFire) begin
            pendPc_d[pendCnt_d[0]] = fetchPc_q;
            pendCnt_d              = pendCnt_d + 2'd1;
        end
    end

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (bus.redirect_valid) begin
            dropCnt_d = pendCnt_q - {1'b0, bus.imem_resp_valid};
        end else if (bus.imem_resp_valid && (dropCnt_q != 2'd0)) begin
            dropCnt_d = dropCnt_q - 2'd1;
        end
    end

    always_comb begin
        bufInstr_d = bufInstr_q;
        bufPc_d    = bufPc_q;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        bufCnt_d   = bufCnt_q;
        if (bus.redirect_valid) begin
            rdPtr_d  = wrPtr_q;
            bufCnt_d = 2'd0;
        end else begin
            if (respKeep) begin
                bufInstr_d[wrPtr_q] = bus.imem_resp_data;
                bufPc_d[wrPtr_q]    = pendPc_q[0];
                wrPtr_d             = ~wrPtr_q;
            end
            if (popHead) begin
                rdPtr_d = ~rdPtr_q;
            end
            case ({respKeep, popHead})
                2'b10:   bufCnt_d = bufCnt_q + 2'd1;
                2'b01:   bufCnt_d = bufCnt_q - 2'd1;
                default: bufCnt_d = bufCnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q   <= {RESET_PC[63:2], 2'b00};
            pendPc_q[0] <= '0;
            pendPc_q[1] <= '0;
            pendCnt_q   <= 2'd0;
            bufInstr_q[0] <= '0;
            bufInstr_q[1] <= '0;
            bufPc_q[0]  <= '0;
            bufPc_q[1]  <= '0;
            rdPtr_q     <= 1'b0;
            wrPtr_q     <= 1'b0;
            bufCnt_q    <= 2'd0;
            dropCnt_q   <= 2'd0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            pendPc_q   <= pendPc_d;
            pendCnt_q  <= pendCnt_d;
            bufInstr_q <= bufInstr_d;
            bufPc_q    <= bufPc_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            bufCnt_q   <= bufCnt_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    assign bus.imem_req_valid = reqValid;
    assign bus.imem_req_addr  = fetchPc_q;
    assign bus.id_valid       = idValid;
    assign bus.id_instruction = bufInstr_q[rdPtr_q];
    assign bus.id_pc          = bufPc_q[rdPtr_q];

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 64-bit RISC-V CPU. It holds the program counter and issues word-aligned requests to instruction memory. It buffers returned instructions with their PCs in a 2-entry queue and hands them to decode, where the immediate generator consumes the instruction word, through a valid/ready handshake. Execute can redirect fetch on a taken branch or jump; a redirect flushes everything younger.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC fetched first after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request present
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  64  fetch address, always word-aligned
- imem_resp_valid  in  1  instruction word returned; in order, at least 1 cycle after acceptance
- imem_resp_data  in  32  returned instruction word
- redirect_valid  in  1  execute redirect (taken branch/jump)
- redirect_pc  in  64  redirect target; bits [1:0] are ignored and treated as 0
- id_valid  out  1  buffer head holds a live instruction
- id_ready  in  1  decode accepts head this cycle
- id_instruction  out  32  head instruction word
- id_pc  out  64  PC of head instruction

## Operation
- State:
  - fetch_pc (64b).
  - Outstanding-request PC queue, depth 2.
  - Output buffer, depth 2, holding {instruction, pc}.
  - drop_cnt (2b).
- Credit rule: imem_req_valid = !rst && !redirect_valid && (occupancy + outstanding + drop_cnt) < 2. This guarantees every response has buffer space, so responses are always accepted (no resp ready signal).
- Request fire (valid && ready):
  - Push fetch_pc into the outstanding queue.
  - fetch_pc <= fetch_pc + 4, with 64-bit wrap-around from 64'hFFFF_FFFF_FFFF_FFFC to 0.
- imem_req_addr = fetch_pc. It changes only after a fire or a redirect. Memory must not rely on valid being held.
- Response while drop_cnt == 0: pop the outstanding queue and push {imem_resp_data, popped pc} into the buffer.
- Response while drop_cnt > 0: discard it, pop the outstanding queue, drop_cnt--.
- Decode fire (id_valid && id_ready): pop the buffer head. Simultaneous push and pop are allowed in the same cycle, at any occupancy.
- Redirect (highest priority below rst):
  - fetch_pc <= {redirect_pc[63:2], 2'b00}.
  - Buffer is flushed; any decode handshake in the same cycle is ignored (the head is killed).
  - No request is issued in the redirect cycle.
  - Any response in the redirect cycle is discarded.
  - drop_cnt <= outstanding − (imem_resp_valid ? 1 : 0) − (drop_cnt > 0 && imem_resp_valid ? 0 : 0), i.e. all still-unanswered requests, including any already being dropped, are marked for drop.
  - Back-to-back redirects: the last one wins.
- Reset:
  - fetch_pc <= RESET_PC; buffer and outstanding queue empty; drop_cnt <= 0.
  - Reset mid-operation abandons in-flight requests. The memory is reset with the same rst and must not return stale responses.

## Timing
- Output values during and immediately after reset: imem_req_valid 0 while rst is high; id_valid 0; id_instruction 0; id_pc 0; imem_req_addr = RESET_PC.
- First cycle after rst falls: imem_req_valid 1, addr RESET_PC.
- Best-case latency, buffer registered:
  - Request fires in cycle N; response arrives in N+1.
  - id_valid rises in N+2.
- Throughput: one instruction per cycle with a 1-cycle memory and id_ready held high.
- Redirect in cycle R:
  - id_valid is 0 in R+1.
  - imem_req_valid is 1 with addr = target in R+1, if credits allow (drop_cnt consumes credits).
  - Earliest id_valid for the target instruction is R+3.
- Buffer full (2 entries) with id_ready low: imem_req_valid stays 0 until a pop. id outputs hold stable.
- Empty buffer: id_valid 0; id_instruction and id_pc hold their last values (don't care).

## Test plan
- Reset, RESET_PC=64'h1000, 1-cycle memory, id_ready=1 → requests 0x1000, 0x1004, 0x1008 on consecutive cycles. id_pc sequence 0x1000, 0x1004, … with the matching words, one per cycle from cycle 2.
- Backpressure: id_ready=0 for 6 cycles → exactly 2 words buffered; imem_req_valid 0 after credits are exhausted. Release → both delivered in order, then fetch resumes with no lost or duplicated PC.
- Redirect with 2 outstanding on a 3-cycle memory, redirect_pc=64'h2002 → the two stale responses are dropped. Next request addr 0x2000; first id_pc after redirect is 0x2000.
- Redirect coinciding with a response and with a decode fire → the response is discarded, the head is killed, and the id_valid sequence shows no stale PC.
- Wrap: redirect_pc=64'hFFFF_FFFF_FFFF_FFFC → next request addrs are …FFFC, then 0x0.
- rst asserted while 2 requests are outstanding and the buffer is full → the next cycle shows id_valid 0, and fetch restarts at RESET_PC.
